// File: rtl/xtea_pkg.sv
// Shared constants, FSM state type and round mixing function for the XTEA-variant
// encoder/decoder pair. Both directions import this package so their arithmetic matches.
package xtea_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned KEY_W   = 128;
    localparam int unsigned DATA_W  = 128;
    localparam int unsigned ROUNDS  = 32;
    localparam int unsigned ROUND_W = 5;

    localparam logic [WORD_W-1:0] DELTA    = 32'h9E3779B9;
    // 32 * DELTA mod 2^32: the sum value after a full encryption.
    localparam logic [WORD_W-1:0] SUM_INIT = 32'hC6EF3720;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ZSTEP = 2'd1,
        YSTEP = 2'd2
    } state_e;

    typedef enum logic {
        PHASE_Y = 1'b0,
        PHASE_Z = 1'b1
    } phase_e;

    // Round mixing: ((v << 4) ^ (v >> 5)) + v, logical shifts, mod 2^32.
    function automatic logic [WORD_W-1:0] mix(input logic [WORD_W-1:0] v);
        return ((v << 4) ^ (v >> 5)) + v;
    endfunction

endpackage

// File: rtl/key_array.sv
// Key schedule word select shared by encoder and decoder.
// Y phase picks k[sum[1:0]], Z phase picks k[sum[12:11]].
module key_array
    import xtea_pkg::*;
(
    input  logic [127:0] key,
    input  logic [31:0]  sum,
    input  logic         phase,
    output logic [31:0]  key_segment
);

    logic [1:0] idx;
    logic       sum_unused;

    // Only four bits of sum participate in the schedule.
    assign sum_unused = ^{sum[31:13], sum[10:2]};

    // Select the key word for the current phase.
    always_comb begin
        idx = sum[1:0];
        if (phase == PHASE_Z) begin
            idx = sum[12:11];
        end
        case (idx)
            2'd0:    key_segment = key[31:0];
            2'd1:    key_segment = key[63:32];
            2'd2:    key_segment = key[95:64];
            default: key_segment = key[127:96];
        endcase
    end

endmodule

// File: rtl/decoder.sv
// Two-block XTEA-variant decoder: 32 inverse rounds, each split into a Z step and a
// Y step, applied to both 64-bit blocks in parallel with a shared sum.
// Optional build macro DECODER_KEY_CAPTURE_EN: register key_in at the accepted start;
// otherwise rounds read key_in directly and it must stay stable while busy.
module decoder
    import xtea_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    input  logic         start,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    output logic [127:0] data_out,
    output logic         busy,
    output logic         done
);

    state_e               state_q, state_d;
    logic [WORD_W-1:0]    sum_q, sum_d;
    logic [ROUND_W-1:0]   round_q, round_d;
    logic [WORD_W-1:0]    y0_q, y0_d, z0_q, z0_d, y1_q, y1_d, z1_q, z1_d;
    logic [DATA_W-1:0]    data_out_q, data_out_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [KEY_W-1:0]     key_use;
    logic                 phase;
    logic [WORD_W-1:0]    key_seg;
    logic [WORD_W-1:0]    sum_key;
    logic [WORD_W-1:0]    z0_new, z1_new, y0_new, y1_new;

`ifdef DECODER_KEY_CAPTURE_EN
    logic [KEY_W-1:0]     key_q, key_d;
    assign key_use = key_q;
`else
    assign key_use = key_in;
`endif

    assign phase = (state_q == ZSTEP) ? PHASE_Z : PHASE_Y;

    key_array u_key_array (
        .key         (key_use),
        .sum         (sum_q),
        .phase       (phase),
        .key_segment (key_seg)
    );

    // Inverse round arithmetic for both blocks; the FSM picks which results to keep.
    always_comb begin
        sum_key = sum_q + key_seg;
        z0_new  = (z0_q ^ sum_key) - mix(y0_q);
        z1_new  = (z1_q ^ sum_key) - mix(y1_q);
        y0_new  = (y0_q ^ sum_key) - mix(z0_q);
        y1_new  = (y1_q ^ sum_key) - mix(z1_q);
    end

    // Next-state and output logic; done is a pulse that drops regardless of enable.
    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        round_d    = round_q;
        y0_d       = y0_q;
        z0_d       = z0_q;
        y1_d       = y1_q;
        z1_d       = z1_q;
        data_out_d = data_out_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef DECODER_KEY_CAPTURE_EN
        key_d      = key_q;
`endif
        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        y0_d    = data_in[31:0];
                        z0_d    = data_in[63:32];
                        y1_d    = data_in[95:64];
                        z1_d    = data_in[127:96];
                        sum_d   = SUM_INIT;
                        round_d = '0;
                        busy_d  = 1'b1;
                        state_d = ZSTEP;
`ifdef DECODER_KEY_CAPTURE_EN
                        key_d   = key_in;
`endif
                    end
                end
                ZSTEP: begin
                    z0_d    = z0_new;
                    z1_d    = z1_new;
                    sum_d   = sum_q - DELTA;
                    state_d = YSTEP;
                end
                YSTEP: begin
                    y0_d    = y0_new;
                    y1_d    = y1_new;
                    round_d = round_q + ROUND_W'(1);
                    if (round_q == ROUND_W'(ROUNDS - 1)) begin
                        data_out_d = {z1_q, y1_new, z0_q, y0_new};
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        state_d = ZSTEP;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            sum_q      <= '0;
            round_q    <= '0;
            y0_q       <= '0;
            z0_q       <= '0;
            y1_q       <= '0;
            z1_q       <= '0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef DECODER_KEY_CAPTURE_EN
            key_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            round_q    <= round_d;
            y0_q       <= y0_d;
            z0_q       <= z0_d;
            y1_q       <= y1_d;
            z1_q       <= z1_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef DECODER_KEY_CAPTURE_EN
            key_q      <= key_d;
`endif
        end
    end

    assign data_out = data_out_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_decoder.sv
// Bench for decoder: ciphertexts come from a forward-cipher model, expected plaintext is
// the original data, and a cycle-count protocol model predicts busy/done/data_out.
module tb_decoder;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b1;
    logic         start = 1'b0;
    logic [127:0] data_in = '0;
    logic [127:0] key_in = '0;
    logic [127:0] data_out;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;
    bit check_on = 1'b0;

    always #5 clock = ~clock;

    decoder dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .start    (start),
        .data_in  (data_in),
        .key_in   (key_in),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- forward cipher model ----------------
    function automatic logic [31:0] m_mix(input logic [31:0] v);
        return ((v << 4) ^ (v >> 5)) + v;
    endfunction

    function automatic logic [63:0] enc_blk(input logic [63:0] blk, input logic [127:0] key,
                                            input int rounds);
        logic [31:0] y, z, s;
        logic [31:0] k [4];
        for (int i = 0; i < 4; i++) k[i] = key[32*i +: 32];
        y = blk[31:0];
        z = blk[63:32];
        s = 32'h0;
        for (int r = 0; r < rounds; r++) begin
            y = (y + m_mix(z)) ^ (s + k[s & 32'h3]);
            s = s + 32'h9E3779B9;
            z = (z + m_mix(y)) ^ (s + k[(s >> 11) & 32'h3]);
        end
        return {z, y};
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] d, input logic [127:0] key,
                                             input int rounds);
        return {enc_blk(d[127:64], key, rounds), enc_blk(d[63:0], key, rounds)};
    endfunction

    // ---------------- protocol model ----------------
    logic [127:0] cur_plain = '0;
    bit           cur_valid = 1'b1;
    bit           m_busy = 1'b0;
    bit           m_done = 1'b0;
    int           m_cnt = 0;
    logic [127:0] m_dout = '0;
    bit           m_dout_valid = 1'b1;
    logic [127:0] m_pend = '0;
    bit           m_pend_valid = 1'b1;

    // A decode takes 64 enabled edges after the accepting edge.
    always @(posedge clock) begin
        if (reset) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_cnt = 0;
            m_dout = '0;
            m_dout_valid = 1'b1;
        end else begin
            m_done = 1'b0;
            if (enable) begin
                if (!m_busy) begin
                    if (start) begin
                        m_busy = 1'b1;
                        m_cnt = 0;
                        m_pend = cur_plain;
                        m_pend_valid = cur_valid;
                    end
                end else begin
                    m_cnt++;
                    if (m_cnt == 64) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                        m_dout = m_pend;
                        m_dout_valid = m_pend_valid;
                    end
                end
            end
        end
    end

    // Compare DUT against the model every cycle.
    always @(negedge clock) begin
        if (check_on) begin
            check("busy", 128'(busy), 128'(m_busy));
            check("done", 128'(done), 128'(m_done));
            if (m_dout_valid) check("data_out", data_out, m_dout);
        end
    end

    // ---------------- stimulus ----------------
    task automatic run(input string name, input logic [127:0] plain, input logic [127:0] key,
                       input int exp_lat, input int stall_at, input int pulse_at,
                       input int key_at, input logic [127:0] key2, input bit valid);
        int cyc;
        bit seen;
        cyc = 0;
        seen = 1'b0;
        data_in = encrypt(plain, key, 32);
        key_in = key;
        cur_plain = plain;
        cur_valid = valid;
        start = 1'b1;
        while (!seen && cyc <= exp_lat + 20) begin
            @(negedge clock);
            cyc++;
            if (done) begin
                seen = 1'b1;
            end else begin
                start = (cyc == pulse_at);
                if (cyc == pulse_at) data_in = ~data_in;
                if (cyc == stall_at) enable = 1'b0;
                if (cyc == stall_at + 10) enable = 1'b1;
                if (cyc == key_at) key_in = key2;
            end
        end
        start = 1'b0;
        enable = 1'b1;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: no done within %0d cycles, required %0d", name, cyc, exp_lat);
        end else begin
            check({name, "_latency"}, 128'(cyc), 128'(exp_lat));
            check({name, "_sum_zero"}, 128'(dut.sum_q), 128'(0));
            if (valid) check({name, "_plain"}, data_out, plain);
        end
    endtask

    localparam logic [127:0] P1 = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] K1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] P2 = 128'hDEADBEEF_CAFEF00D_13579BDF_2468ACE0;
    localparam logic [127:0] K2 = 128'hFFFFFFFF_00000001_80000000_7FFFFFFF;
    localparam logic [127:0] P3 = 128'h00000000_FFFFFFFF_A5A5A5A5_5A5A5A5A;

    initial begin
        int dn;
        // Pin the model against hand-computed values.
        check("model_mix_1", 128'(m_mix(32'h1)), 128'h11);
        check("model_mix_20", 128'(m_mix(32'h20)), 128'h221);
        check("model_mix_ff", 128'(m_mix(32'hFFFFFFFF)), 128'hF800000E);
        check("model_round1", encrypt(128'h0, 128'h0, 1),
              128'h9E3779B9_00000000_9E3779B9_00000000);

        repeat (3) @(negedge clock);
        reset = 1'b0;
        check_on = 1'b1;
        check("reset_data_out", data_out, 128'h0);
        check("reset_busy", 128'(busy), 128'h0);
        check("reset_done", 128'(done), 128'h0);
        repeat (100) @(negedge clock);
        check("idle_data_out", data_out, 128'h0);
        check("idle_busy", 128'(busy), 128'h0);

        run("zero", 128'h0, 128'h0, 65, -1, -1, -1, '0, 1'b1);
        repeat (3) @(negedge clock);
        run("nonzero", P1, K1, 65, -1, -1, -1, '0, 1'b1);
        repeat (2) @(negedge clock);
        run("stall", P2, K2, 75, 20, -1, -1, '0, 1'b1);
        repeat (2) @(negedge clock);

        // Abort with reset at cycle 30 of a run.
        data_in = encrypt(P3, K1, 32);
        key_in = K1;
        cur_plain = P3;
        cur_valid = 1'b1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (29) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_data_out", data_out, 128'h0);
        check("abort_busy", 128'(busy), 128'h0);
        dn = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (done) dn++;
        end
        check("abort_no_done", 128'(dn), 128'h0);
        run("after_abort", P3, K1, 65, -1, -1, -1, '0, 1'b1);

        // Back-to-back: next start in the done cycle.
        run("b2b_first", P1, K2, 65, -1, -1, -1, '0, 1'b1);
        run("b2b_second", P2, K1, 65, -1, -1, -1, '0, 1'b1);
        repeat (2) @(negedge clock);

        // Start pulsed while busy (with different data_in) is ignored.
        run("busy_start", P3, K2, 65, -1, 30, -1, '0, 1'b1);
        repeat (2) @(negedge clock);

        // Key change mid-run.
`ifdef DECODER_KEY_CAPTURE_EN
        run("key_change", P1, K1, 65, -1, -1, 20, K2, 1'b1);
`else
        run("key_change", P1, K1, 65, -1, -1, 20, K2, 1'b0);
`endif
        repeat (2) @(negedge clock);
        run("final", P2, K2, 65, -1, -1, -1, '0, 1'b1);
        repeat (5) @(negedge clock);
        check("final_idle_busy", 128'(busy), 128'h0);

        check_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
